vx_hamming_dec_pipe: RTL

- Two-stage pipelined SECDED checker/corrector for codewords read back from ECC-protected cache data storage.
- Consumes the codeword layout produced by the cache Hamming encoder and returns corrected data with error flags.
- Uses a valid/ready handshake on both sides.
- Keeps saturating corrected/uncorrectable event counters and sticky status for the cache CSR path.

---
 rtl/vx_hamming_dec_pipe.sv | 136 +++++++++++++
 1 files changed

// File: rtl/vx_hamming_dec_pipe.sv
// Two-stage SECDED checker/corrector for cache ECC codewords, with valid/ready
// flow control, saturating event counters and a sticky uncorrectable flag.
module vx_hamming_dec_pipe #(
   parameter int DATA_BITS    = 128,
   parameter int HAMMING_BITS = $clog2(DATA_BITS + $clog2(DATA_BITS) + 1),
   parameter int ENCODED_BITS = DATA_BITS + HAMMING_BITS + 1,
   parameter int CNT_BITS     = 16
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [ENCODED_BITS-1:0] in_code,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [DATA_BITS-1:0]    out_data,
   output logic                    out_corrected,
   output logic                    out_uncorrectable,
   output logic [HAMMING_BITS:0]   out_err_pos,
   input  logic                    cnt_clear,
   output logic [CNT_BITS-1:0]     cnt_corrected,
   output logic [CNT_BITS-1:0]     cnt_uncorrectable,
   output logic                    sticky_uncorrectable
);

   typedef struct packed {
      logic [HAMMING_BITS-1:0] syn;
      logic                    par;
      logic [ENCODED_BITS-1:0] code;
   } s1_t;

   // Codeword index holding data bit d: the d-th non-power-of-two position.
   function automatic int data_idx(input int d);
      int n;
      n = 0;
      for (int p = 1; p < ENCODED_BITS; p++) begin
         if ((p & (p - 1)) != 0) begin
            if (n == d) return p - 1;
            n++;
         end
      end
      return 0;
   endfunction

   logic [2:1] vld_pipe;
   s1_t        s1_q, s1_d;
   logic       adv2, ld1, ld2, hs;

   assign adv2      = !vld_pipe[2] || out_ready;
   assign ld2       = vld_pipe[1] && adv2;
   assign in_ready  = !vld_pipe[1] || adv2;
   assign ld1       = in_valid && in_ready;
   assign out_valid = vld_pipe[2];
   assign hs        = out_valid && out_ready;

   always_comb begin
      s1_d      = '0;
      s1_d.code = in_code;
      s1_d.par  = ^in_code;
      for (int c = 1; c < ENCODED_BITS; c++)
         for (int k = 0; k < HAMMING_BITS; k++)
            if (c[k]) s1_d.syn[k] = s1_d.syn[k] ^ in_code[c-1];
   end

   logic [ENCODED_BITS-1:0] fixed;
   logic [DATA_BITS-1:0]    data_x;
   logic                    corr_x, unc_x;
   logic [HAMMING_BITS:0]   pos_x;

   always_comb begin
      fixed  = s1_q.code;
      corr_x = 1'b0;
      unc_x  = 1'b0;
      pos_x  = '0;
      if (s1_q.syn == '0) begin
         // Only the overall parity bit flipped; payload is already intact.
         if (s1_q.par) begin
            corr_x = 1'b1;
            pos_x  = (HAMMING_BITS+1)'(ENCODED_BITS);
         end
      end else if (!s1_q.par || int'(s1_q.syn) > ENCODED_BITS - 1) begin
         unc_x = 1'b1;
      end else begin
         corr_x = 1'b1;
         pos_x  = {1'b0, s1_q.syn};
         fixed[int'(s1_q.syn) - 1] = ~s1_q.code[int'(s1_q.syn) - 1];
      end
   end

   for (genvar g = 0; g < DATA_BITS; g++) begin : g_extract
      localparam int IDX = data_idx(g);
      assign data_x[g] = fixed[IDX];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld_pipe          <= '0;
         s1_q              <= '0;
         out_data          <= '0;
         out_corrected     <= 1'b0;
         out_uncorrectable <= 1'b0;
         out_err_pos       <= '0;
      end else begin
         if (ld1)      vld_pipe[1] <= 1'b1;
         else if (ld2) vld_pipe[1] <= 1'b0;
         if (ld2)            vld_pipe[2] <= 1'b1;
         else if (out_ready) vld_pipe[2] <= 1'b0;
         if (ld1) s1_q <= s1_d;
         if (ld2) begin
            out_data          <= data_x;
            out_corrected     <= corr_x;
            out_uncorrectable <= unc_x;
            out_err_pos       <= pos_x;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_corrected        <= '0;
         cnt_uncorrectable    <= '0;
         sticky_uncorrectable <= 1'b0;
      end else if (cnt_clear) begin
         cnt_corrected        <= '0;
         cnt_uncorrectable    <= '0;
         sticky_uncorrectable <= 1'b0;
      end else if (hs) begin
         if (out_corrected && cnt_corrected != '1)
            cnt_corrected <= cnt_corrected + 1'b1;
         if (out_uncorrectable && cnt_uncorrectable != '1)
            cnt_uncorrectable <= cnt_uncorrectable + 1'b1;
         if (out_uncorrectable) sticky_uncorrectable <= 1'b1;
      end
   end

endmodule
